spi_xip_ctrl: RTL and testbench
===============================

Name: spi_xip_ctrl

Overview:
- Execute-in-place front end between the APB crossbar and the SPI master register file.
- Upstream APB reads that hit the flash window are turned into a fixed sequence of SPI register accesses:
  - load TX with command 0x03 plus the address;
  - program the divider and slave select;
  - start the transfer, poll for completion, read RX, deselect.
- The returned word is byte-swapped and delivered as the APB read data.
- Every non-flash access passes through unchanged, so software keeps direct SPI register access.

Parameters:
- FLASH_BASE, 32'h30000000, start of flash window (inclusive).
- FLASH_END, 32'h3fffffff, end of flash window (inclusive).
- SPI_DIV, 32'h00000001, value written to DIVIDER (offset 0x14).
- SPI_SS_MASK, 32'h00000001, value written to SS (offset 0x18) to select the flash.
- CTRL_VAL, 32'h00002440, CTRL value (offset 0x10) without GO: ASS | TX_NEG | CHAR_LEN=64.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_paddr  in  32  upstream APB address.
- in_psel  in  1  upstream select.
- in_penable  in  1  upstream enable.
- in_pprot  in  3  upstream protection.
- in_pwrite  in  1  upstream write.
- in_pwdata  in  32  upstream write data.
- in_pstrb  in  4  upstream strobes.
- in_pready  out  1  upstream ready.
- in_prdata  out  32  upstream read data.
- in_pslverr  out  1  upstream error.
- out_paddr  out  32  downstream APB address to the SPI master.
- out_psel  out  1  downstream select.
- out_penable  out  1  downstream enable.
- out_pprot  out  3  downstream protection.
- out_pwrite  out  1  downstream write.
- out_pwdata  out  32  downstream write data.
- out_pstrb  out  4  downstream strobes.
- out_pready  in  1  downstream ready.
- out_prdata  in  32  downstream read data.
- out_pslverr  in  1  downstream error.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE;
  - all out_* = 0; in_pready = 0; in_prdata = 0; in_pslverr = 0.
- Window hit: FLASH_BASE <= in_paddr <= FLASH_END, sampled only in the setup phase (in_psel=1, in_penable=0) while in IDLE.
- IDLE, non-hit setup -> PASS.
- PASS (combinational pass-through):
  - out_* = in_*; in_pready = out_pready; in_prdata = out_prdata; in_pslverr = out_pslverr.
  - Returns to IDLE in the cycle after out_pready=1 with in_penable=1.
- IDLE, hit with in_pwrite=1 -> ERR.
  - ERR: in_pready=1 and in_pslverr=1 in the access phase; no downstream activity; then IDLE.
- IDLE, hit read -> XIP sequence. Each step is one downstream APB transfer: setup cycle, then access cycles until out_pready. Order:
  1. WR_TX1: write 0x04 = {8'h03, in_paddr[23:2], 2'b00}.
  2. WR_TX0: write 0x00 = 0.
  3. WR_DIV: write 0x14 = SPI_DIV.
  4. WR_SS: write 0x18 = SPI_SS_MASK.
  5. WR_GO: write 0x10 = CTRL_VAL | 32'h100.
  6. POLL: read 0x10; repeat while out_prdata[8]=1.
  7. RD_RX: read 0x00; latch the read data.
  8. CLR_SS: write 0x18 = 0.
  9. RESP: in_pready=1 for exactly one cycle; in_prdata = byte-swap of the latched word ({b0, b1, b2, b3} order); then IDLE.
- Address handling: the flash address is captured in the setup phase; in_paddr[1:0] is ignored (word fetch).
- Downstream out_pstrb=4'hf for every write; out_pprot is copied from the captured in_pprot.
- Upstream in_pready stays 0 throughout the sequence; upstream signals are held per APB and are not re-sampled.
- Downstream error: any out_pslverr=1 during the sequence jumps to CLR_SS; RESP then sets in_pslverr=1 and in_prdata=0.
- POLL has no timeout; a stuck GO_BSY stalls the bus. This is intentional and matches the SPI master guarantee.
- Minimum XIP latency, setup to in_pready with out_pready always 1: 8 transfers x 2 cycles + 1 RESP cycle + 1 = 18 cycles.
- Reset asserted mid-sequence: immediate return to IDLE with outputs at reset values. SS may remain latched inside the SPI master; software re-init is required.

Decomposition:
- Package spi_xip_pkg:
  - state enum;
  - register offsets: RX0/TX0=0x00, TX1=0x04, CTRL=0x10, DIV=0x14, SS=0x18;
  - GO_BSY bit index 8;
  - read command 8'h03.
- Sub-module spi_xip_apb_xfer: single downstream APB transfer engine.
  - Inputs: start, addr, wdata, write.
  - Outputs: done, rdata, err.
  - Drives the setup/access phases.
- The top FSM sequences spi_xip_apb_xfer and muxes it with the PASS path.

Test Plan:
- Pass-through:
  - Stimulus: write 0x10001014 = 0x5 from upstream.
  - Response: out_paddr=0x10001014, out_pwdata=0x5 in the same cycles; in_pready mirrors out_pready with 2 wait states.
- XIP read:
  - Stimulus: read 0x30000104; SPI model returns RX0=0x11223344, GO_BSY clears on the 3rd poll.
  - Response: downstream log is TX1=0x03000104, TX0=0, DIV=1, SS=1, CTRL=0x2540, 3 reads of 0x10, read 0x00, SS=0; in_prdata=0x44332211.
- Flash write:
  - Stimulus: write 0x30000000.
  - Response: in_pslverr=1 and in_pready=1 in the first access cycle; out_psel stays 0.
- Downstream error:
  - Stimulus: out_pslverr=1 on the WR_DIV transfer.
  - Response: next transfer is SS=0, then in_pslverr=1 and in_prdata=0.
- Reset mid-POLL:
  - Stimulus: drive reset=0 asynchronously.
  - Response: out_psel=0 and in_pready=0 without waiting for a clock edge; a following read of 0x30000000 completes normally.
- Window boundaries:
  - Stimulus: 0x2fffffff, then 0x3fffffff, then 0x40000000.
  - Response: pass, XIP (TX1=0x03fffffc), pass.

Source files
------------

// File: rtl/spi_xip_pkg.sv
// Shared types and SPI master register map for the XIP front end.
package spi_xip_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PASS,
      ST_ERR,
      ST_WR_TX1,
      ST_WR_TX0,
      ST_WR_DIV,
      ST_WR_SS,
      ST_WR_GO,
      ST_POLL,
      ST_RD_RX,
      ST_CLR_SS,
      ST_RESP
   } xip_state_e;

   localparam logic [31:0] REG_RX0  = 32'h00;
   localparam logic [31:0] REG_TX0  = 32'h00;
   localparam logic [31:0] REG_TX1  = 32'h04;
   localparam logic [31:0] REG_CTRL = 32'h10;
   localparam logic [31:0] REG_DIV  = 32'h14;
   localparam logic [31:0] REG_SS   = 32'h18;

   localparam int          GO_BSY_BIT = 8;
   localparam logic [31:0] GO_MASK    = 32'h0000_0100;
   localparam logic [7:0]  CMD_READ   = 8'h03;

   // Flash returns the first byte on the wire in the MSB of RX; the bus wants it in the LSB.
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/spi_xip_apb_xfer.sv
// One downstream APB transfer: setup cycle while start is first seen, then access until pready.
module spi_xip_apb_xfer (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        write_i,
   input  logic        pready_i,
   input  logic [31:0] prdata_i,
   input  logic        pslverr_i,
   output logic        psel_o,
   output logic        penable_o,
   output logic [31:0] paddr_o,
   output logic [31:0] pwdata_o,
   output logic        pwrite_o,
   output logic [3:0]  pstrb_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   logic access_q, access_d;

   // start_i is held by the sequencer for the whole transfer; dropping to setup after done
   // lets a held start_i launch the next transfer back to back.
   assign access_d = start_i & ~(access_q & pready_i);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) access_q <= 1'b0;
      else        access_q <= access_d;
   end

   assign psel_o    = start_i;
   assign penable_o = start_i & access_q;
   assign paddr_o   = addr_i;
   assign pwrite_o  = write_i;
   assign pwdata_o  = write_i ? wdata_i : '0;
   assign pstrb_o   = write_i ? 4'hf : 4'h0;
   assign done_o    = start_i & access_q & pready_i;
   assign rdata_o   = prdata_i;
   assign err_o     = done_o & pslverr_i;

endmodule

// File: rtl/spi_xip_ctrl.sv
// XIP front end: flash-window reads become an SPI register sequence, everything else passes through.
module spi_xip_ctrl
   import spi_xip_pkg::*;
#(
   parameter logic [31:0] FLASH_BASE  = 32'h3000_0000,
   parameter logic [31:0] FLASH_END   = 32'h3fff_ffff,
   parameter logic [31:0] SPI_DIV     = 32'h0000_0001,
   parameter logic [31:0] SPI_SS_MASK = 32'h0000_0001,
   parameter logic [31:0] CTRL_VAL    = 32'h0000_2440
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_paddr,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic [2:0]  in_pprot,
   input  logic        in_pwrite,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   output logic        in_pready,
   output logic [31:0] in_prdata,
   output logic        in_pslverr,
   output logic [31:0] out_paddr,
   output logic        out_psel,
   output logic        out_penable,
   output logic [2:0]  out_pprot,
   output logic        out_pwrite,
   output logic [31:0] out_pwdata,
   output logic [3:0]  out_pstrb,
   input  logic        out_pready,
   input  logic [31:0] out_prdata,
   input  logic        out_pslverr
);

   xip_state_e  state_q, state_d, step_nxt;
   logic [31:0] addr_q, rx_q;
   logic [2:0]  prot_q;
   logic        err_q;
   logic        setup, hit, pass_en;

   logic        xf_start, xf_write, xf_psel, xf_penable, xf_pwrite, xf_done, xf_err;
   logic [31:0] xf_addr, xf_wdata, xf_paddr, xf_pwdata, xf_rdata;
   logic [3:0]  xf_pstrb;

   assign setup = in_psel & ~in_penable;
   assign hit   = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);

   spi_xip_apb_xfer u_xfer (
      .clock     (clock),
      .reset     (reset),
      .start_i   (xf_start),
      .addr_i    (xf_addr),
      .wdata_i   (xf_wdata),
      .write_i   (xf_write),
      .pready_i  (out_pready),
      .prdata_i  (out_prdata),
      .pslverr_i (out_pslverr),
      .psel_o    (xf_psel),
      .penable_o (xf_penable),
      .paddr_o   (xf_paddr),
      .pwdata_o  (xf_pwdata),
      .pwrite_o  (xf_pwrite),
      .pstrb_o   (xf_pstrb),
      .done_o    (xf_done),
      .rdata_o   (xf_rdata),
      .err_o     (xf_err)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         prot_q  <= '0;
         err_q   <= 1'b0;
         rx_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && setup && hit) begin
            addr_q <= in_paddr;
            prot_q <= in_pprot;
            err_q  <= 1'b0;
         end
         if (xf_err) err_q <= 1'b1;
         if (state_q == ST_RD_RX && xf_done) rx_q <= xf_rdata;
      end
   end

   always_comb begin
      state_d     = state_q;
      step_nxt    = ST_IDLE;
      pass_en     = 1'b0;
      xf_start    = 1'b0;
      xf_addr     = '0;
      xf_wdata    = '0;
      xf_write    = 1'b0;
      in_pready   = 1'b0;
      in_prdata   = '0;
      in_pslverr  = 1'b0;
      out_paddr   = '0;
      out_psel    = 1'b0;
      out_penable = 1'b0;
      out_pprot   = '0;
      out_pwrite  = 1'b0;
      out_pwdata  = '0;
      out_pstrb   = '0;

      case (state_q)
         ST_IDLE: begin
            if (setup) begin
               if (!hit) begin
                  // Forward the setup phase now so the SPI master sees a legal APB transfer.
                  pass_en = reset;
                  state_d = ST_PASS;
               end else if (in_pwrite) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_WR_TX1;
               end
            end
         end
         ST_PASS: begin
            pass_en = 1'b1;
            if (in_penable && out_pready) state_d = ST_IDLE;
         end
         ST_ERR: begin
            in_pready  = 1'b1;
            in_pslverr = 1'b1;
            state_d    = ST_IDLE;
         end
         ST_RESP: begin
            in_pready  = 1'b1;
            in_pslverr = err_q;
            in_prdata  = err_q ? '0 : bswap32(rx_q);
            state_d    = ST_IDLE;
         end
         default: begin
            xf_start = 1'b1;
            case (state_q)
               ST_WR_TX1: begin
                  xf_addr  = REG_TX1;
                  xf_wdata = {CMD_READ, addr_q[23:2], 2'b00};
                  xf_write = 1'b1;
                  step_nxt = ST_WR_TX0;
               end
               ST_WR_TX0: begin xf_addr = REG_TX0; xf_write = 1'b1; step_nxt = ST_WR_DIV; end
               ST_WR_DIV: begin xf_addr = REG_DIV; xf_wdata = SPI_DIV; xf_write = 1'b1; step_nxt = ST_WR_SS; end
               ST_WR_SS:  begin xf_addr = REG_SS; xf_wdata = SPI_SS_MASK; xf_write = 1'b1; step_nxt = ST_WR_GO; end
               ST_WR_GO: begin
                  xf_addr  = REG_CTRL;
                  xf_wdata = CTRL_VAL | GO_MASK;
                  xf_write = 1'b1;
                  step_nxt = ST_POLL;
               end
               ST_POLL:   begin xf_addr = REG_CTRL; step_nxt = xf_rdata[GO_BSY_BIT] ? ST_POLL : ST_RD_RX; end
               ST_RD_RX:  begin xf_addr = REG_RX0; step_nxt = ST_CLR_SS; end
               ST_CLR_SS: begin xf_addr = REG_SS; xf_write = 1'b1; step_nxt = ST_RESP; end
               default:   step_nxt = ST_IDLE;
            endcase
            // A downstream error still deselects the flash before answering.
            if (xf_done) state_d = (xf_err && state_q != ST_CLR_SS) ? ST_CLR_SS : step_nxt;
         end
      endcase

      if (pass_en) begin
         out_paddr   = in_paddr;
         out_psel    = in_psel;
         out_penable = in_penable;
         out_pprot   = in_pprot;
         out_pwrite  = in_pwrite;
         out_pwdata  = in_pwdata;
         out_pstrb   = in_pstrb;
         in_pready   = out_pready;
         in_prdata   = out_prdata;
         in_pslverr  = out_pslverr;
      end else if (xf_start) begin
         out_paddr   = xf_paddr;
         out_psel    = xf_psel;
         out_penable = xf_penable;
         out_pprot   = prot_q;
         out_pwrite  = xf_pwrite;
         out_pwdata  = xf_pwdata;
         out_pstrb   = xf_pstrb;
      end
   end

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// Scoreboard bench: APB master stimulus, behavioural SPI master model, decoupled monitors.
module tb_spi_xip_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] in_paddr = '0;
   logic        in_psel = 1'b0, in_penable = 1'b0, in_pwrite = 1'b0;
   logic [2:0]  in_pprot = '0;
   logic [31:0] in_pwdata = '0;
   logic [3:0]  in_pstrb = '0;
   logic        in_pready, in_pslverr;
   logic [31:0] in_prdata;
   logic [31:0] out_paddr, out_pwdata, out_prdata;
   logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
   logic [2:0]  out_pprot;
   logic [3:0]  out_pstrb;

   always #5 clock = ~clock;

   spi_xip_ctrl dut (
      .clock(clock), .reset(reset),
      .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable), .in_pprot(in_pprot),
      .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
      .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
      .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot),
      .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
      .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
   );

   typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } dn_t;
   typedef struct { logic chk_rd; logic [31:0] rdata; logic err; int lat; } up_t;

   dn_t exp_dn[$];
   up_t exp_up[$];
   dn_t d;
   up_t e;
   int  n_chk = 0, n_fail = 0;
   bit  mon_en = 1'b0;

   // SPI master model knobs (written by stimulus) and state (written by the model).
   int          ws_cfg = 0, busy_polls = 1, err_at = 0;
   bit          err_en = 1'b0;
   logic [31:0] rx_val = '0;
   int          ws_cnt = 0, poll_cnt = 0, xfer_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'h5a5a_a5a5;
   endfunction

   function automatic dn_t mk(input logic wr, input logic [31:0] a, input logic [31:0] dat);
      dn_t r;
      r.wr = wr; r.addr = a; r.data = dat;
      return r;
   endfunction

   always_comb begin
      out_pready = out_psel && out_penable && (ws_cnt >= ws_cfg);
      out_prdata = dflt(out_paddr);
      if (out_paddr == 32'h10)
         out_prdata = (poll_cnt + 1 < busy_polls) ? 32'h0000_2540 : 32'h0000_2440;
      else if (out_paddr == 32'h0)
         out_prdata = rx_val;
      out_pslverr = out_pready && err_en && (xfer_total == err_at);
   end

   always @(posedge clock) begin
      if (out_psel && out_penable && !out_pready) ws_cnt <= ws_cnt + 1;
      else ws_cnt <= 0;
      if (out_psel && out_penable && out_pready) begin
         xfer_total <= xfer_total + 1;
         if (out_paddr == 32'h10) poll_cnt <= out_pwrite ? 0 : poll_cnt + 1;
      end
   end

   // Reference: the downstream transfer list and upstream answer an access should produce.
   task automatic expect_txn(input logic [31:0] a, input bit wr, input logic [31:0] wd);
      dn_t l[$];
      up_t r;
      bit  err;
      int  eidx;
      eidx = err_en ? err_at - xfer_total : -1;
      if (a < 32'h3000_0000 || a > 32'h3fff_ffff) begin
         l.push_back(mk(wr, a, wr ? wd : 32'h0));
         r.chk_rd = !wr; r.rdata = dflt(a); r.err = (eidx == 0); r.lat = ws_cfg + 1;
      end else if (wr) begin
         r.chk_rd = 1'b0; r.rdata = '0; r.err = 1'b1; r.lat = 1;
      end else begin
         l.push_back(mk(1, 32'h04, {8'h03, a[23:2], 2'b00}));
         l.push_back(mk(1, 32'h00, 32'h0));
         l.push_back(mk(1, 32'h14, 32'h1));
         l.push_back(mk(1, 32'h18, 32'h1));
         l.push_back(mk(1, 32'h10, 32'h2540));
         for (int i = 0; i < busy_polls; i++) l.push_back(mk(0, 32'h10, 32'h0));
         l.push_back(mk(0, 32'h00, 32'h0));
         l.push_back(mk(1, 32'h18, 32'h0));
         err = (eidx >= 0) && (eidx < l.size());
         if (err && eidx < l.size() - 1) begin
            while (l.size() > eidx + 1) void'(l.pop_back());
            l.push_back(mk(1, 32'h18, 32'h0));
         end
         r.chk_rd = 1'b1;
         r.rdata  = err ? 32'h0 : {rx_val[7:0], rx_val[15:8], rx_val[23:16], rx_val[31:24]};
         r.err    = err;
         r.lat    = l.size() * (2 + ws_cfg) + 1;
      end
      foreach (l[i]) exp_dn.push_back(l[i]);
      exp_up.push_back(r);
   endtask

   task automatic apb(input logic [31:0] a, input bit wr, input logic [31:0] wd);
      int n;
      expect_txn(a, wr, wd);
      @(posedge clock); #1;
      in_paddr = a; in_pwrite = wr; in_pwdata = wd; in_pstrb = wr ? 4'hf : 4'h0;
      in_pprot = 3'($urandom); in_psel = 1'b1; in_penable = 1'b0;
      @(posedge clock); #1 in_penable = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!in_pready && n < 3000);
      chk("pready_seen", 32'(in_pready), 32'h1);
      @(posedge clock); #1 in_psel = 1'b0; in_penable = 1'b0;
   endtask

   int acc = 0;
   always @(negedge clock) begin
      if (!mon_en || !(in_psel && in_penable)) acc = 0;
      else begin
         acc = acc + 1;
         if (in_pready) begin
            if (exp_up.size() == 0) chk("up_unexpected", 32'h1, 32'h0);
            else begin
               e = exp_up.pop_front();
               chk("latency", 32'(acc), 32'(e.lat));
               chk("slverr", 32'(in_pslverr), 32'(e.err));
               if (e.chk_rd) chk("prdata", in_prdata, e.rdata);
            end
            acc = 0;
         end
      end
   end

   always @(negedge clock) begin
      if (mon_en && out_psel && out_penable && out_pready) begin
         if (exp_dn.size() == 0) chk("dn_unexpected", out_paddr, 32'hdead_beef);
         else begin
            d = exp_dn.pop_front();
            chk("dn_addr", out_paddr, d.addr);
            chk("dn_write", 32'(out_pwrite), 32'(d.wr));
            if (d.wr) chk("dn_wdata", out_pwdata, d.data);
            chk("dn_pstrb", 32'(out_pstrb), d.wr ? 32'hf : 32'h0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int          k, n;
   logic [31:0] ra;

   initial begin
      reset = 1'b0;
      in_psel = 1'b1; in_paddr = 32'h1000_0000;
      #12;
      chk("rst_out_psel", 32'(out_psel), 32'h0);
      chk("rst_out_paddr", out_paddr, 32'h0);
      chk("rst_in_pready", 32'(in_pready), 32'h0);
      chk("rst_in_prdata", in_prdata, 32'h0);
      chk("rst_in_pslverr", 32'(in_pslverr), 32'h0);
      in_psel = 1'b0;
      @(posedge clock); #1 reset = 1'b1; mon_en = 1'b1;

      ws_cfg = 2; apb(32'h1000_1014, 1, 32'h5);
      ws_cfg = 0; busy_polls = 1; rx_val = 32'hcafe_f00d; apb(32'h3000_0200, 0, 0);
      busy_polls = 3; rx_val = 32'h1122_3344; apb(32'h3000_0104, 0, 0);
      apb(32'h3000_0000, 1, 32'h1234_5678);
      err_en = 1'b1; err_at = xfer_total + 2; busy_polls = 1; apb(32'h3000_0010, 0, 0);
      err_en = 1'b0;
      rx_val = 32'ha1b2_c3d4;
      apb(32'h2fff_ffff, 0, 0);
      apb(32'h3fff_ffff, 0, 0);
      apb(32'h4000_0000, 0, 0);

      // Reset while the controller is polling GO_BSY.
      mon_en = 1'b0; busy_polls = 1000;
      @(posedge clock); #1 in_paddr = 32'h3000_0040; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
      @(posedge clock); #1 in_penable = 1'b1;
      n = 0;
      while (!(out_psel && out_paddr == 32'h10 && !out_pwrite) && n < 200) begin @(negedge clock); n++; end
      chk("poll_reached", 32'(out_psel && out_paddr == 32'h10 && !out_pwrite), 32'h1);
      repeat (4) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("arst_out_psel", 32'(out_psel), 32'h0);
      chk("arst_out_penable", 32'(out_penable), 32'h0);
      chk("arst_in_pready", 32'(in_pready), 32'h0);
      in_psel = 1'b0; in_penable = 1'b0;
      @(posedge clock); #1 reset = 1'b1; busy_polls = 1; mon_en = 1'b1;
      rx_val = 32'h0102_0304; apb(32'h3000_0000, 0, 0);

      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 3);
         ws_cfg = $urandom_range(0, 2); busy_polls = $urandom_range(1, 4); rx_val = $urandom;
         err_en = ($urandom_range(0, 3) == 0); err_at = xfer_total + $urandom_range(0, 12);
         ra = $urandom;
         case (k)
            0: apb(32'h1000_0000 | (ra & 32'h0fff_fffc), 1'($urandom_range(0, 1)), $urandom);
            1: apb(32'h4000_0000 | (ra & 32'h0fff_fffc), 1'($urandom_range(0, 1)), $urandom);
            2: apb(32'h3000_0000 | (ra & 32'h0fff_ffff), 0, 0);
            default: apb(32'h3000_0000 | (ra & 32'h0fff_ffff), 1, $urandom);
         endcase
      end
      err_en = 1'b0;

      repeat (5) @(posedge clock);
      chk("dn_queue_empty", 32'(exp_dn.size()), 32'h0);
      chk("up_queue_empty", 32'(exp_up.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
